div_ctrl: RTL and testbench

// - EX-stage controller that sits directly upstream of the iterative divider (div).
// - Accepts DIV/DIVU from EX and latches the operands for the whole operation.
// - Drives the divider start/annul handshake and stalls the pipeline until the result is back.
// - Delivers {hi,lo} to the HILO write path with a one-cycle write-enable pulse.

---
 rtl/div_ctrl.sv | 149 ++++++++++++++
 tb/tb_div_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage controller in front of the iterative divider.
//
// Latches the operands of a DIV/DIVU, holds the divider start request while it
// works, stalls the pipeline, and hands the {hi,lo} result to the HILO write
// path with a one-cycle write-enable pulse. A flush or a timeout annuls the
// divide.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   div_req_i, div_signed_i  DIV/DIVU request from EX and its signedness
//   reg1_i, reg2_i           dividend / divisor from EX
//   flush_i, ex_stall_i      pipeline flush, downstream stall holding EX
//   div_result_i             {remainder, quotient} from the divider
//   div_ready_i              divider result valid
//   div_start_o/annul_o      divider start / cancel
//   div_signed_o, div_op*_o  latched mode and operands to the divider
//   stallreq_o               stall request to the pipeline controller
//   hi_o, lo_o, whilo_o      result to HILO and its write-enable pulse
//   err_o                    timeout pulse
module div_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_req_i,
    input  logic               div_signed_i,
    input  logic [WIDTH-1:0]   reg1_i,
    input  logic [WIDTH-1:0]   reg2_i,
    input  logic               flush_i,
    input  logic               ex_stall_i,
    input  logic [2*WIDTH-1:0] div_result_i,
    input  logic               div_ready_i,
    output logic               div_start_o,
    output logic               div_annul_o,
    output logic               div_signed_o,
    output logic [WIDTH-1:0]   div_op1_o,
    output logic [WIDTH-1:0]   div_op2_o,
    output logic               stallreq_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic               whilo_o,
    output logic               err_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             whilo_q, whilo_d;
    logic             err_q, err_d;
    logic             annul_q, annul_d;

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        whilo_d = 1'b0;
        err_d   = 1'b0;
        annul_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (div_req_i && !flush_i) begin
                    op1_d   = reg1_i;
                    op2_d   = reg2_i;
                    sgn_d   = div_signed_i;
                    cnt_d   = 8'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (flush_i) begin
                    annul_d = 1'b1;
                    state_d = StIdle;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[2*WIDTH-1:WIDTH];
                    lo_d    = div_result_i[WIDTH-1:0];
                    whilo_d = 1'b1;
                    state_d = StDone;
                end else if (cnt_q >= TimeoutCnt) begin
                    err_d   = 1'b1;
                    annul_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                // A request still held here belongs to the finished instruction.
                if (!ex_stall_i || flush_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op1_q   <= '0;
            op2_q   <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= 8'd0;
            whilo_q <= 1'b0;
            err_q   <= 1'b0;
            annul_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            whilo_q <= whilo_d;
            err_q   <= err_d;
            annul_q <= annul_d;
        end
    end

    // The stall must rise in the accepting cycle itself, so it is decoded from the live request.
    assign stallreq_o   = !rst && ((state_q == StIdle && div_req_i && !flush_i) ||
                                   state_q == StBusy);
    assign div_start_o  = !rst && (state_q == StBusy);
    assign div_annul_o  = annul_q;
    assign div_signed_o = sgn_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign whilo_o      = whilo_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a behavioural divider answers div_start_o after a
// configurable latency; vector table plus random divides and corner sequences.
module tb_div_ctrl;

    localparam int W  = 32;
    localparam int TO = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_req_i = 1'b0;
    logic          div_signed_i = 1'b0;
    logic [W-1:0]  reg1_i = '0;
    logic [W-1:0]  reg2_i = '0;
    logic          flush_i = 1'b0;
    logic          ex_stall_i = 1'b0;
    logic [2*W-1:0] div_result_i;
    logic          div_ready_i;
    logic          div_start_o, div_annul_o, div_signed_o;
    logic [W-1:0]  div_op1_o, div_op2_o;
    logic          stallreq_o;
    logic [W-1:0]  hi_o, lo_o;
    logic          whilo_o, err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_req_i    (div_req_i),
        .div_signed_i (div_signed_i),
        .reg1_i       (reg1_i),
        .reg2_i       (reg2_i),
        .flush_i      (flush_i),
        .ex_stall_i   (ex_stall_i),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .stallreq_o   (stallreq_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .whilo_o      (whilo_o),
        .err_o        (err_o)
    );

    // Reference: MIPS division semantics, divide-by-zero yields zero.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: ready pulses 'lat_cfg' cycles after start first appears.
    int          lat_cfg = 34;
    bit          tie0 = 1'b0;
    int          dcnt = 0;
    logic        rdy_q = 1'b0;
    logic [63:0] res_q = 64'd0;

    always @(posedge clk) begin
        if (rst || !div_start_o || div_annul_o || rdy_q) begin
            dcnt  <= 0;
            rdy_q <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            if (!tie0 && dcnt + 1 == lat_cfg) begin
                rdy_q <= 1'b1;
                res_q <= ref_div(div_signed_o, div_op1_o, div_op2_o);
            end
        end
    end

    assign div_ready_i  = rdy_q;
    assign div_result_i = res_q;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          scr;
        int          hold;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] b,
                                input int lat, input bit scr, input int hold,
                                input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.sgn = s; v.a = a; v.b = b; v.lat = lat; v.scr = scr; v.hold = hold;
        v.hi = hi; v.lo = lo;
        return v;
    endfunction

    task automatic run_div(input vec_t v, input string tag);
        int  busy;
        bit  got;
        lat_cfg = v.lat;
        tie0    = 1'b0;
        @(posedge clk); #1;
        div_req_i = 1'b1; div_signed_i = v.sgn; reg1_i = v.a; reg2_i = v.b;
        #1;
        check({tag, ":stall_accept"}, 96'(stallreq_o), 96'd1);
        busy = 0;
        got  = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk); #1;
            if (whilo_o) begin
                got = 1'b1;
            end else begin
                busy++;
                check({tag, ":busy"}, {div_start_o, stallreq_o, div_signed_o, div_op1_o, div_op2_o},
                      {1'b1, 1'b1, v.sgn, v.a, v.b});
                if (v.scr) begin
                    reg1_i = $urandom; reg2_i = $urandom; div_signed_i = ~div_signed_i;
                end
            end
        end
        if (!got) begin
            check({tag, ":whilo_seen"}, 96'd0, 96'd1);
            div_req_i = 1'b0;
            return;
        end
        check({tag, ":latency"}, 96'(busy), 96'(v.lat + 1));
        check({tag, ":result"}, {hi_o, lo_o}, {v.hi, v.lo});
        check({tag, ":done_quiet"}, {stallreq_o, div_start_o, div_annul_o, err_o}, 96'd0);
        if (v.hold > 0) begin
            ex_stall_i = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk); #1;
                check({tag, ":hold"}, {whilo_o, div_start_o, stallreq_o, hi_o, lo_o},
                      {3'b000, v.hi, v.lo});
            end
            ex_stall_i = 1'b0;
        end
        div_req_i = 1'b0;
        @(posedge clk); #1;
        check({tag, ":idle_after"}, {whilo_o, div_start_o, stallreq_o}, 96'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   busy;
        bit   got;
        logic s;
        logic [31:0] a, b;

        // Reset with a request pending: everything must stay quiet.
        div_req_i = 1'b1; reg1_i = 32'h1234; reg2_i = 32'h5;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o, err_o},
              96'd0);
        check("reset_data", {div_op1_o, div_op2_o, hi_o}, 96'd0);
        check("reset_lo", 96'(lo_o), 96'd0);
        div_req_i = 1'b0;
        rst = 1'b0;

        tbl.push_back(mk(1'b1, 32'd100, 32'd7, 34, 1'b0, 0, 32'd2, 32'd14));
        tbl.push_back(mk(1'b1, 32'hFFFF_FFF9, 32'd2, 34, 1'b0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
        tbl.push_back(mk(1'b0, 32'hFFFF_FFFF, 32'd1, 34, 1'b0, 0, 32'd0, 32'hFFFF_FFFF));
        tbl.push_back(mk(1'b0, 32'd1000, 32'd33, 20, 1'b1, 0, 32'd10, 32'd30));
        tbl.push_back(mk(1'b1, 32'd100, 32'd7, 10, 1'b0, 5, 32'd2, 32'd14));
        tbl.push_back(mk(1'b0, 32'd5, 32'd0, 34, 1'b0, 0, 32'd0, 32'd0));
        tbl.push_back(mk(1'b0, 32'd77, 32'd8, TO, 1'b0, 0, 32'd5, 32'd9));
        tbl.push_back(mk(1'b1, 32'hFFFF_FF9C, 32'd7, 1, 1'b0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFF2));
        foreach (tbl[i]) run_div(tbl[i], $sformatf("vec%0d", i));

        // Request during flush in IDLE is ignored.
        @(posedge clk); #1;
        div_req_i = 1'b1; flush_i = 1'b1; reg1_i = 32'd9; reg2_i = 32'd3;
        #1;
        check("idle_flush_stall", 96'(stallreq_o), 96'd0);
        @(posedge clk); #1;
        check("idle_flush_start", 96'(div_start_o), 96'd0);
        div_req_i = 1'b0; flush_i = 1'b0;

        // Flush on BUSY cycle 10.
        lat_cfg = 40;
        @(posedge clk); #1;
        div_req_i = 1'b1; div_signed_i = 1'b1; reg1_i = 32'd100; reg2_i = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        check("flush_busy", {div_start_o, stallreq_o}, 96'd3);
        flush_i = 1'b1; div_req_i = 1'b0;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_annul", {div_annul_o, whilo_o, stallreq_o, div_start_o}, 96'b1000);
        @(posedge clk); #1;
        check("flush_after", {div_annul_o, whilo_o, div_start_o}, 96'd0);
        run_div(mk(1'b1, 32'd100, 32'd7, 34, 1'b0, 0, 32'd2, 32'd14), "post_flush");

        // Divider never answers: timeout abort.
        tie0 = 1'b1;
        @(posedge clk); #1;
        div_req_i = 1'b1; div_signed_i = 1'b0; reg1_i = 32'd5; reg2_i = 32'd3;
        busy = 0;
        got  = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk); #1;
            div_req_i = 1'b0;
            if (err_o) got = 1'b1;
            else busy++;
        end
        check("tmo_seen", 96'(got), 96'd1);
        check("tmo_cycles", 96'(busy), 96'(TO + 1));
        check("tmo_flags", {err_o, div_annul_o, whilo_o, stallreq_o, div_start_o}, 96'b11000);
        @(posedge clk); #1;
        check("tmo_after", {err_o, div_annul_o, div_start_o, stallreq_o}, 96'd0);
        tie0 = 1'b0;

        // Randomized divides against the reference.
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom % 2);
            a = $urandom;
            b = ($urandom % 4 == 0) ? 32'($urandom % 16) : 32'($urandom);
            if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            v = mk(s, a, b, int'($urandom_range(1, TO)), bit'($urandom % 2),
                   int'($urandom % 3), 32'd0, 32'd0);
            {v.hi, v.lo} = ref_div(s, a, b);
            run_div(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a divide.
        lat_cfg = 40;
        @(posedge clk); #1;
        div_req_i = 1'b1; div_signed_i = 1'b1; reg1_i = 32'hDEAD; reg2_i = 32'h11;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1; div_req_i = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_ctl", {div_start_o, stallreq_o, whilo_o, div_annul_o, err_o,
                               div_signed_o}, 96'd0);
        check("rst_busy_ops", {div_op1_o, div_op2_o}, 96'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_idle", {div_start_o, stallreq_o}, 96'd0);
        run_div(mk(1'b0, 32'd1000, 32'd33, 30, 1'b0, 0, 32'd10, 32'd30), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
